// File: rtl/fp2_operand_sequencer_pkg.sv
// Shared types and encodings for the Fp/Fp2 operand sequencer feeding the preadder.
// Also holds the slot schedule tables used to pick X/Y sources and modes per slot.
package fp2_operand_sequencer_pkg;

    localparam int LIMBS  = 3;
    localparam int LIMB_W = 32;

    typedef logic [LIMBS-1:0][LIMB_W-1:0] redundant_poly_L3;

    typedef enum logic [1:0] {
        OP_FP_MUL  = 2'b00,
        OP_FP2_MUL = 2'b01,
        OP_FP2_SQR = 2'b10,
        OP_RSVD    = 2'b11
    } op_e;

    localparam logic [1:0] MODE_PASS = 2'b00;
    localparam logic [1:0] MODE_ACC  = 2'b01;
    localparam logic [1:0] MODE_XY   = 2'b10;

    localparam logic [1:0] IDX_LO  = 2'd0;
    localparam logic [1:0] IDX_HI  = 2'd1;
    localparam logic [1:0] IDX_MID = 2'd2;

    typedef enum logic [1:0] {
        SEL_A0B0,
        SEL_A1B1,
        SEL_A0A1
    } sel_e;

    typedef struct packed {
        sel_e       sel;
        logic [1:0] mode1;
        logic [1:0] mode2;
        logic [1:0] idx;
        logic       last;
    } slot_t;

    function automatic logic [1:0] slot_count(input op_e op);
        case (op)
            OP_FP_MUL:  return 2'd1;
            OP_FP2_MUL: return 2'd3;
            OP_FP2_SQR: return 2'd2;
            default:    return 2'd0;
        endcase
    endfunction

    // The middle Karatsuba slot of FP2_MUL relies on the preadder still holding slot 1.
    function automatic slot_t slot_info(input op_e op, input logic [1:0] slot);
        slot_t s;
        s = '{sel: SEL_A0B0, mode1: MODE_PASS, mode2: MODE_PASS, idx: IDX_LO, last: 1'b0};
        case (op)
            OP_FP_MUL: s.last = 1'b1;
            OP_FP2_MUL: begin
                if (slot == 2'd1) begin
                    s.sel = SEL_A1B1;
                    s.idx = IDX_HI;
                end else if (slot == 2'd2) begin
                    s.mode1 = MODE_ACC;
                    s.mode2 = MODE_XY;
                    s.idx   = IDX_MID;
                    s.last  = 1'b1;
                end
            end
            OP_FP2_SQR: begin
                s.sel = SEL_A0A1;
                if (slot == 2'd0) begin
                    s.mode1 = MODE_XY;
                    s.mode2 = MODE_ACC;
                    s.idx   = IDX_MID;
                end else begin
                    s.last = 1'b1;
                end
            end
            default: s.last = 1'b0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/fp2_operand_sequencer_sideband_delay.sv
// Fixed-depth shift register that lines the {valid, tag, idx, last} sideband up
// with the preadder outputs; cleared synchronously so aborted work never emerges.
module fp2_operand_sequencer_sideband_delay #(
    parameter int W     = 8,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] pipe [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/fp2_operand_sequencer.sv
// Accepts Fp/Fp2 multiply/square requests and drives the preadder X/Y/mode inputs
// slot by slot so its Z0/Z1 outputs form the Karatsuba partial-product operands.
module fp2_operand_sequencer
    import fp2_operand_sequencer_pkg::*;
#(
    parameter int TAG_W        = 4,
    parameter int SIDEBAND_DLY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [TAG_W-1:0] req_tag,
    input  redundant_poly_L3 a0,
    input  redundant_poly_L3 a1,
    input  redundant_poly_L3 b0,
    input  redundant_poly_L3 b1,
    output redundant_poly_L3 X,
    output redundant_poly_L3 Y,
    output logic [1:0]       mode1,
    output logic [1:0]       mode2,
    output logic             z_valid,
    output logic [TAG_W-1:0] z_tag,
    output logic [1:0]       z_idx,
    output logic             z_last,
    output logic             err
);

    typedef enum logic {IDLE, ISSUE} state_e;

    state_e           state;
    logic [1:0]       rem;
    op_e              op_q;
    logic [TAG_W-1:0] tag_q;
    redundant_poly_L3 a0_q, a1_q, b0_q, b1_q;

    logic             sb_valid, sb_last;
    logic [TAG_W-1:0] sb_tag;
    logic [1:0]       sb_idx;

    logic             accept, issue;
    op_e              req_op_e, cur_op;
    logic [1:0]       cur_slot, next_rem;
    slot_t            cur;
    logic [TAG_W-1:0] cur_tag;
    redundant_poly_L3 cur_a0, cur_a1, cur_b0, cur_b1, cur_x, cur_y;

    assign req_ready = (state == IDLE) || (rem == 2'd0);
    assign accept    = req_valid && req_ready;
    assign req_op_e  = op_e'(req_op);

    // A fresh accept issues slot 0 straight from the ports; otherwise continue from latched operands.
    always_comb begin
        cur_op   = op_q;
        cur_slot = slot_count(op_q) - rem;
        cur_tag  = tag_q;
        cur_a0   = a0_q;
        cur_a1   = a1_q;
        cur_b0   = b0_q;
        cur_b1   = b1_q;
        next_rem = rem - 2'd1;
        issue    = (state == ISSUE) && (rem != 2'd0);
        if (accept) begin
            cur_op   = req_op_e;
            cur_slot = 2'd0;
            cur_tag  = req_tag;
            cur_a0   = a0;
            cur_a1   = a1;
            cur_b0   = b0;
            cur_b1   = b1;
            next_rem = slot_count(req_op_e) - 2'd1;
            issue    = (req_op_e != OP_RSVD);
        end
        cur = slot_info(cur_op, cur_slot);
        case (cur.sel)
            SEL_A1B1: begin
                cur_x = cur_a1;
                cur_y = cur_b1;
            end
            SEL_A0A1: begin
                cur_x = cur_a0;
                cur_y = cur_a1;
            end
            default: begin
                cur_x = cur_a0;
                cur_y = cur_b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rem      <= 2'd0;
            op_q     <= OP_FP_MUL;
            tag_q    <= '0;
            a0_q     <= '0;
            a1_q     <= '0;
            b0_q     <= '0;
            b1_q     <= '0;
            X        <= '0;
            Y        <= '0;
            mode1    <= MODE_PASS;
            mode2    <= MODE_PASS;
            sb_valid <= 1'b0;
            sb_tag   <= '0;
            sb_idx   <= IDX_LO;
            sb_last  <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (accept) begin
                op_q  <= req_op_e;
                tag_q <= req_tag;
                a0_q  <= a0;
                a1_q  <= a1;
                b0_q  <= b0;
                b1_q  <= b1;
            end
            if (issue) begin
                state    <= ISSUE;
                rem      <= next_rem;
                X        <= cur_x;
                Y        <= cur_y;
                mode1    <= cur.mode1;
                mode2    <= cur.mode2;
                sb_valid <= 1'b1;
                sb_tag   <= cur_tag;
                sb_idx   <= cur.idx;
                sb_last  <= cur.last;
                err      <= 1'b0;
            end else begin
                // Reaching here with an accept means the reserved op was taken and dropped.
                state    <= IDLE;
                rem      <= 2'd0;
                X        <= '0;
                Y        <= '0;
                mode1    <= MODE_PASS;
                mode2    <= MODE_PASS;
                sb_valid <= 1'b0;
                sb_tag   <= '0;
                sb_idx   <= IDX_LO;
                sb_last  <= 1'b0;
                err      <= accept;
            end
        end
    end

    logic [TAG_W+3:0] sb_out;

    fp2_operand_sequencer_sideband_delay #(
        .W     (TAG_W + 4),
        .DEPTH (SIDEBAND_DLY)
    ) u_sideband_delay (
        .clk  (clk),
        .rst  (rst),
        .din  ({sb_valid, sb_tag, sb_idx, sb_last}),
        .dout (sb_out)
    );

    assign {z_valid, z_tag, z_idx, z_last} = sb_out;

endmodule

// File: tb/tb_fp2_operand_sequencer.sv
// Scoreboard bench for fp2_operand_sequencer: the driver pushes the expected slot
// schedule per accepted request, and a negedge monitor compares every cycle.
module tb_fp2_operand_sequencer;
    import fp2_operand_sequencer_pkg::*;

    localparam int TAG_W = 4;
    localparam int DLY   = 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [1:0]       req_op = 2'b00;
    logic [TAG_W-1:0] req_tag = '0;
    redundant_poly_L3 a0 = '0, a1 = '0, b0 = '0, b1 = '0;
    redundant_poly_L3 X, Y;
    logic [1:0]       mode1, mode2;
    logic             z_valid, z_last, err;
    logic [TAG_W-1:0] z_tag;
    logic [1:0]       z_idx;

    fp2_operand_sequencer #(.TAG_W(TAG_W), .SIDEBAND_DLY(DLY)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_tag(req_tag), .a0(a0), .a1(a1), .b0(b0), .b1(b1),
        .X(X), .Y(Y), .mode1(mode1), .mode2(mode2), .z_valid(z_valid),
        .z_tag(z_tag), .z_idx(z_idx), .z_last(z_last), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               cyc;
        redundant_poly_L3 x;
        redundant_poly_L3 y;
        logic [1:0]       m1;
        logic [1:0]       m2;
    } xbeat_t;

    typedef struct {
        int               cyc;
        logic [TAG_W-1:0] tag;
        logic [1:0]       idx;
        logic             last;
    } zbeat_t;

    xbeat_t xq[$];
    zbeat_t zq[$];
    int     errq[$];
    int     cyc = 0;
    int     readyUntil = 0;
    int     testCount = 0;
    int     failCount = 0;
    bit     checking = 1'b0;

    function automatic redundant_poly_L3 poly(input int unsigned v);
        return redundant_poly_L3'({64'd0, v});
    endfunction

    function automatic redundant_poly_L3 randPoly();
        return redundant_poly_L3'({$urandom, $urandom, $urandom});
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        testCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic pushBeat(input int c, input redundant_poly_L3 x, input redundant_poly_L3 y,
                            input logic [1:0] m1, input logic [1:0] m2,
                            input logic [TAG_W-1:0] tag, input logic [1:0] idx, input logic last);
        xq.push_back('{c, x, y, m1, m2});
        zq.push_back('{c + DLY, tag, idx, last});
    endtask

    // Reference schedule straight from the slot tables: one entry per cycle after acceptance edge e.
    task automatic modelAccept(input int e, input logic [1:0] op, input logic [TAG_W-1:0] tag,
                               input redundant_poly_L3 pa0, input redundant_poly_L3 pa1,
                               input redundant_poly_L3 pb0, input redundant_poly_L3 pb1);
        case (op)
            2'b00: begin
                pushBeat(e, pa0, pb0, 2'b00, 2'b00, tag, 2'd0, 1'b1);
                readyUntil = e;
            end
            2'b01: begin
                pushBeat(e,     pa0, pb0, 2'b00, 2'b00, tag, 2'd0, 1'b0);
                pushBeat(e + 1, pa1, pb1, 2'b00, 2'b00, tag, 2'd1, 1'b0);
                pushBeat(e + 2, pa0, pb0, 2'b01, 2'b10, tag, 2'd2, 1'b1);
                readyUntil = e + 2;
            end
            2'b10: begin
                pushBeat(e,     pa0, pa1, 2'b10, 2'b01, tag, 2'd2, 1'b0);
                pushBeat(e + 1, pa0, pa1, 2'b00, 2'b00, tag, 2'd0, 1'b1);
                readyUntil = e + 1;
            end
            default: begin
                errq.push_back(e);
                readyUntil = e;
            end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (rst) begin
            xq.delete();
            zq.delete();
            errq.delete();
            readyUntil = 0;
            checking = 1'b1;
        end
        #1;
    endtask

    task automatic applyStimulus(input bit v, input logic [1:0] op, input logic [TAG_W-1:0] tag,
                                 input redundant_poly_L3 pa0, input redundant_poly_L3 pa1,
                                 input redundant_poly_L3 pb0, input redundant_poly_L3 pb1,
                                 output bit accepted);
        bit modelReady;
        req_valid = v;
        req_op    = op;
        req_tag   = tag;
        a0 = pa0; a1 = pa1; b0 = pb0; b1 = pb1;
        modelReady = (cyc >= readyUntil);
        if (checking) checkOutput("req_ready", 128'(req_ready), 128'(modelReady));
        accepted = v && !rst && modelReady;
        tick();
        if (accepted) modelAccept(cyc, op, tag, pa0, pa1, pb0, pb1);
    endtask

    task automatic sendReq(input logic [1:0] op, input logic [TAG_W-1:0] tag,
                           input redundant_poly_L3 pa0, input redundant_poly_L3 pa1,
                           input redundant_poly_L3 pb0, input redundant_poly_L3 pb1);
        bit acc;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, op, tag, pa0, pa1, pb0, pb1, acc);
            if (acc) return;
        end
        testCount++;
        failCount++;
        $display("[TB] FAIL accept_timeout at cycle %0d: got no accept, expected accept within 6 cycles", cyc);
    endtask

    task automatic idleCycles(input int n);
        bit acc;
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'b00, '0, '0, '0, '0, '0, acc);
    endtask

    task automatic checkResetState();
        checkOutput("rst_X", 128'(X), 128'(0));
        checkOutput("rst_Y", 128'(Y), 128'(0));
        checkOutput("rst_modes", 128'({mode1, mode2}), 128'(0));
        checkOutput("rst_z", 128'({z_valid, z_tag, z_idx, z_last}), 128'(0));
        checkOutput("rst_err", 128'(err), 128'(0));
        checkOutput("rst_ready", 128'(req_ready), 128'(1));
    endtask

    always @(negedge clk) begin : monitor
        redundant_poly_L3 ex, ey;
        logic [1:0]       em1, em2, eidx;
        logic [TAG_W-1:0] etag;
        logic             ezv, elast, eerr;
        if (checking) begin
            ex = '0; ey = '0; em1 = 2'b00; em2 = 2'b00;
            if (xq.size() > 0 && xq[0].cyc == cyc) begin
                ex = xq[0].x; ey = xq[0].y; em1 = xq[0].m1; em2 = xq[0].m2;
                void'(xq.pop_front());
            end
            checkOutput("X", 128'(X), 128'(ex));
            checkOutput("Y", 128'(Y), 128'(ey));
            checkOutput("mode1", 128'(mode1), 128'(em1));
            checkOutput("mode2", 128'(mode2), 128'(em2));

            ezv = 1'b0; etag = '0; eidx = 2'd0; elast = 1'b0;
            if (zq.size() > 0 && zq[0].cyc == cyc) begin
                ezv = 1'b1; etag = zq[0].tag; eidx = zq[0].idx; elast = zq[0].last;
                void'(zq.pop_front());
            end
            checkOutput("z_valid", 128'(z_valid), 128'(ezv));
            if (ezv) begin
                checkOutput("z_tag", 128'(z_tag), 128'(etag));
                checkOutput("z_idx", 128'(z_idx), 128'(eidx));
                checkOutput("z_last", 128'(z_last), 128'(elast));
            end

            eerr = 1'b0;
            if (errq.size() > 0 && errq[0] == cyc) begin
                eerr = 1'b1;
                void'(errq.pop_front());
            end
            checkOutput("err", 128'(err), 128'(eerr));
        end
    end

    initial begin
        bit acc;
        rst = 1'b1;
        idleCycles(1);
        checkResetState();
        rst = 1'b0;

        sendReq(2'b01, 4'd4, poly(3), poly(5), poly(7), poly(11));
        idleCycles(4);

        sendReq(2'b10, 4'd9, poly(3), poly(5), poly(0), poly(0));
        idleCycles(4);

        sendReq(2'b00, 4'd1, poly(2), poly(0), poly(9), poly(0));
        sendReq(2'b01, 4'd2, poly(3), poly(5), poly(7), poly(11));
        sendReq(2'b00, 4'd3, poly(4), poly(6), poly(8), poly(10));
        idleCycles(4);

        sendReq(2'b00, 4'd5, poly(12), poly(0), poly(13), poly(0));
        sendReq(2'b11, 4'd6, poly(1), poly(1), poly(1), poly(1));
        sendReq(2'b00, 4'd7, poly(14), poly(0), poly(15), poly(0));
        idleCycles(4);

        sendReq(2'b01, 4'd8, poly(21), poly(22), poly(23), poly(24));
        idleCycles(1);
        rst = 1'b1;
        idleCycles(1);
        checkResetState();
        rst = 1'b0;
        sendReq(2'b00, 4'd10, poly(31), poly(0), poly(32), poly(0));
        idleCycles(4);

        idleCycles(10);

        for (int i = 0; i < 300; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), TAG_W'($urandom),
                          randPoly(), randPoly(), randPoly(), randPoly(), acc);
        end
        idleCycles(6);

        checkOutput("x_queue_drained", 128'(xq.size()), 128'(0));
        checkOutput("z_queue_drained", 128'(zq.size()), 128'(0));
        checkOutput("err_queue_drained", 128'(errq.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
